// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and the ShiftRows permutation.
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORD_W  = 32;
  localparam int AES_NB      = 4;   // columns per block
  localparam int CNT_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

  // Byte (r,c) lives at [127-8*(4c+r) -: 8]; row r rotates left by r columns.
  function automatic logic [AES_BLOCK_W-1:0] shift_rows(input logic [AES_BLOCK_W-1:0] s);
    logic [AES_BLOCK_W-1:0] o;
    o = '0;
    for (int c = 0; c < AES_NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[AES_BLOCK_W-1-8*(4*c+r) -: 8] = s[AES_BLOCK_W-1-8*(4*((c+r)%AES_NB)+r) -: 8];
      end
    end
    return o;
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: GF(2^8) inverse (as x^254) followed by the affine map.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;

  // x^254 = x^2 * x^4 * ... * x^128, which also maps 0 to 0
  always_comb begin
    x2   = gmul(a_i, a_i);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
    s_o  = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

// File: rtl/enc_last_round_iter.sv
// AES final round, one column of SubBytes per cycle, then ShiftRows + key XOR.
module enc_last_round_iter
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] state_in,
  input  logic [AES_BLOCK_W-1:0] key_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] state_out,
  output logic                   busy
);
  enc_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_BLOCK_W-1:0] work_q, work_d, key_q, key_d, out_q, out_d;
  logic [AES_BLOCK_W-1:0] sub_state;
  logic [AES_WORD_W-1:0]  col_in, col_sub;
  int                     col_hi;

  // Select the column addressed by the counter (column 0 is the MSW)
  always_comb begin
    col_hi = AES_BLOCK_W - 1 - AES_WORD_W * int'(cnt_q);
    col_in = work_q[col_hi -: AES_WORD_W];
    sub_state = work_q;
    sub_state[col_hi -: AES_WORD_W] = col_sub;
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i (col_in[AES_WORD_W-1-8*b -: 8]),
      .s_o (col_sub[AES_WORD_W-1-8*b -: 8])
    );
  end

  // Next-state, datapath updates and result load
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    key_d   = key_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = state_in;
          key_d   = key_in;
          cnt_d   = '0;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        work_d = sub_state;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(AES_NB - 1)) begin
          // sub_state already carries the last substituted column
          out_d   = shift_rows(sub_state) ^ key_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset wipes any in-flight block
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      key_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      key_q   <= key_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE) && !rst;
  assign busy      = ((state_q == ST_SUB) || (state_q == ST_DONE)) && !rst;
  assign state_out = out_q;
endmodule

// File: doc/enc_last_round_iter.md
ENC_LAST_ROUND_ITER -- requirements
Module: enc_last_round_iter

Interface
REQ-001 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1, upstream offers state_in/key_in.
REQ-004 SHALL have port in_ready, output, 1, block can accept a new block.
REQ-005 SHALL have port state_in, input, 128, round-10 input state; bits [127:120] are byte 0; column-major (FIPS-197).
REQ-006 SHALL have port key_in, input, 128, round-10 key; same byte order as state_in.
REQ-007 SHALL have port out_valid, output, 1, state_out holds a valid result.
REQ-008 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-009 SHALL have port state_out, output, 128, ciphertext = AddRoundKey(ShiftRows(SubBytes(state_in)), key_in).
REQ-010 SHALL have port busy, output, 1, high in SUB or DONE.

Function
REQ-011 SHALL implement the FSM states IDLE, SUB and DONE.
REQ-012 SHALL assert in_ready only in IDLE.
REQ-013 SHALL accept a block when in_valid&&in_ready: latch state_in and key_in, clear word counter, go to SUB.
REQ-014 SHALL substitute exactly one 32-bit column per SUB cycle (counter 0..3), replacing column k of the working register through 4 forward S-boxes.
REQ-015 SHALL, in the SUB cycle with counter=3, load state_out with ShiftRows(substituted state) XOR latched key and go to DONE.
REQ-016 SHALL implement ShiftRows as row r rotated left by r byte positions (r=0..3), combinationally.
REQ-017 SHALL assert out_valid exactly 4 cycles after the accept cycle, and hold it only in DONE.
REQ-018 SHALL hold state_out and out_valid stable while out_valid && !out_ready (backpressure).
REQ-019 SHALL return to IDLE on out_valid&&out_ready, with out_valid low and in_ready high the next cycle.
REQ-020 SHALL ignore in_valid in SUB and DONE, without corrupting latched data.
REQ-021 SHALL keep state_out at its last value after handoff until the next result load.
REQ-022 SHALL give a throughput of at most one block per 6 cycles; no overlap between blocks.

Reset
REQ-023 SHALL on rst force IDLE and set counter=0, state_out=128'h0, out_valid=0, busy=0, in_ready=0 during the reset cycle and 1 after.
REQ-024 SHALL give rst priority over all handshakes; rst mid-SUB or mid-DONE discards the block, produces no out_valid, and clears the working registers to 0.

Structure
REQ-025 SHALL take state encodings, AES_BLOCK_W=128, AES_WORD_W=32 and the column-count constant from shared package aes_pkg.
REQ-026 SHALL use a combinational forward S-box sub-module aes_sbox (8-bit in/out), instantiated 4 times for one column.
REQ-027 SHALL implement ShiftRows and the key XOR inline, with no inverse transforms.

Verification
REQ-028 SHALL verify the FIPS-197 App.B vector: state_in=eb40f21e592e38848ba113e71bc342d2, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, out_ready=1 -> out_valid 4 cycles after accept, state_out=3925841d02dc09fbdc118597196a0b32.
REQ-029 SHALL verify all-zero state and key -> state_out=636363...63 (16 bytes of 63).
REQ-030 SHALL verify backpressure: out_ready=0 for 10 cycles after out_valid -> state_out and out_valid stable and in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-031 SHALL verify a busy drop: in_valid pulsed with a different block during SUB -> ignored; result matches the first block only.
REQ-032 SHALL verify reset mid-operation: rst at SUB counter=2 -> out_valid never rises, state_out=0, in_ready=1 the cycle after rst deasserts.
REQ-033 SHALL verify back-to-back: 2 blocks with in_valid held high and out_ready=1 -> both results correct, out_valid pulses 6 cycles apart.
